// File: rtl/vga_board_capture.sv
// vga_board_capture
// Loopback receiver for the TinyVGA PMOD byte of the Game-of-Life VGA top.
// The raster position is rebuilt from the hsync/vsync falling edges only.
// Once tracking is locked, one full frame can be captured. Capturing samples
// the centre pixel of every displayed 8x8 cell and streams the 256 board bits
// together with their board index.
module vga_board_capture #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_SYNC_START = 656,
    parameter int V_SYNC_START = 490
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_in,
    input  logic       cap_en,
    output logic       locked,
    output logic       sync_err,
    output logic       cap_busy,
    output logic       cell_valid,
    output logic [7:0] cell_addr,
    output logic       cell_alive,
    output logic       frame_done
);

    // PMOD byte layout: {hsync, B0, G0, R0, vsync, B1, G1, R1}
    localparam int HS_BIT = 7;
    localparam int VS_BIT = 3;
    localparam int G1_BIT = 1;
    localparam int R1_BIT = 0;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC  = 10'(H_SYNC_START);
    localparam logic [9:0]  V_SYNC  = 10'(V_SYNC_START);
    localparam logic [10:0] H_GAP   = 11'(H_TOTAL - 1);
    localparam logic [10:0] GAP_MAX = 11'h7FF;

    // The board is 16x16 cells of 8x8 pixels. It is drawn at hpos 192..319
    // and vpos 256..383. Because of where the window starts, hpos[6:3] runs
    // 8..15 and then 0..7 across a row.
    localparam logic [9:0] BOARD_H_LO  = 10'd192;
    localparam logic [9:0] BOARD_H_HI  = 10'd319;
    localparam logic [9:0] BOARD_V_LO  = 10'd256;
    localparam logic [9:0] BOARD_V_HI  = 10'd383;
    localparam logic [2:0] CELL_CENTRE = 3'd4;
    localparam logic [7:0] LAST_CELL   = 8'd255;

    typedef enum logic [1:0] {
        ST_UNLOCKED   = 2'd0,
        ST_IDLE       = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_CAPTURE    = 2'd3
    } state_e;

    // Input stage
    logic [7:0]  s_q, s_prev_q;
    logic        hs_fall, vs_fall;

    // Raster tracking
    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic [9:0]  hc_cur, vc_cur;
    logic [10:0] hs_gap_q, hs_gap_d;
    logic        hs_seen_q, hs_pair_ok_q, hs_pair_ok_d;

    // Capture control
    state_e      state_q, state_d;
    logic [7:0]  cell_cnt_q, cell_cnt_d;
    logic        sync_bad, take_cell, last_cell;
    logic        in_board, cell_hit;
    logic [7:0]  disp_idx;

    // Registered outputs
    logic        sync_err_q, cell_valid_q, cell_alive_q, frame_done_q;
    logic [7:0]  cell_addr_q;

    // The blue and upper-nibble colour bits carry nothing this block needs.
    logic        unused_pmod_bits;
    assign unused_pmod_bits = ^{s_q[6:4], s_q[2], s_prev_q[6:4], s_prev_q[2:0]};

    assign hs_fall = s_prev_q[HS_BIT] & ~s_q[HS_BIT];
    assign vs_fall = s_prev_q[VS_BIT] & ~s_q[VS_BIT];

    // Register the PMOD byte and keep the previous sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= 8'hFF;
            s_prev_q <= 8'hFF;
        end else begin
            s_q      <= vga_in;
            s_prev_q <= s_q;
        end
    end

    // Position of the sample in s. A sync fall pins that sample to the sync
    // start position. The registers hold the free-running prediction, and the
    // lock check compares against that prediction.
    always_comb begin
        hc_cur = hc_q;
        vc_cur = vc_q;
        if (hs_fall) begin
            hc_cur = H_SYNC;
        end
        if (vs_fall) begin
            vc_cur = V_SYNC;
        end
        hc_d = (hc_cur == H_LAST) ? 10'd0 : hc_cur + 10'd1;
        vc_d = vc_cur;
        if (hc_cur == H_LAST) begin
            vc_d = (vc_cur == V_LAST) ? 10'd0 : vc_cur + 10'd1;
        end
    end

    // Advance the raster counters so they follow the next sample into s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Measure the spacing of hsync falls. A lock needs the latest two falls to
    // be exactly one line apart.
    always_comb begin
        if (hs_fall) begin
            hs_gap_d = 11'd0;
        end else if (hs_gap_q == GAP_MAX) begin
            hs_gap_d = hs_gap_q;
        end else begin
            hs_gap_d = hs_gap_q + 11'd1;
        end
        hs_pair_ok_d = hs_pair_ok_q;
        if (hs_fall) begin
            hs_pair_ok_d = hs_seen_q && (hs_gap_q == H_GAP);
        end
    end

    // Hold the hsync spacing measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_gap_q     <= 11'd0;
            hs_seen_q    <= 1'b0;
            hs_pair_ok_q <= 1'b0;
        end else begin
            hs_gap_q     <= hs_gap_d;
            hs_seen_q    <= hs_seen_q | hs_fall;
            hs_pair_ok_q <= hs_pair_ok_d;
        end
    end

    assign sync_bad = (hs_fall && (hc_q != H_SYNC)) || (vs_fall && (vc_q != V_SYNC));

    assign in_board = (hc_cur >= BOARD_H_LO) && (hc_cur <= BOARD_H_HI) &&
                      (vc_cur >= BOARD_V_LO) && (vc_cur <= BOARD_V_HI);
    assign cell_hit = in_board && (hc_cur[2:0] == CELL_CENTRE) && (vc_cur[2:0] == CELL_CENTRE);
    assign disp_idx = {vc_cur[6:3], hc_cur[6:3]};

    // Lock and capture sequencing. A sync contradiction wins over everything
    // else and drops any capture in progress.
    always_comb begin
        state_d    = state_q;
        cell_cnt_d = cell_cnt_q;
        take_cell  = 1'b0;
        last_cell  = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (vs_fall && hs_pair_ok_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sync_bad) begin
                    state_d = ST_UNLOCKED;
                end else if (cap_en) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (sync_bad) begin
                    state_d = ST_UNLOCKED;
                end else if ((hc_cur == 10'd0) && (vc_cur == 10'd0)) begin
                    state_d    = ST_CAPTURE;
                    cell_cnt_d = 8'd0;
                end
            end
            ST_CAPTURE: begin
                if (sync_bad) begin
                    state_d = ST_UNLOCKED;
                end else if (cell_hit) begin
                    take_cell  = 1'b1;
                    cell_cnt_d = cell_cnt_q + 8'd1;
                    if (cell_cnt_q == LAST_CELL) begin
                        last_cell = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
    end

    // State and cell counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNLOCKED;
            cell_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cell_cnt_q <= cell_cnt_d;
        end
    end

    // Output registers. Address and state are held between cell pulses.
    // The display shows board cell c+1 at position c, so the index is bumped
    // by one and allowed to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q   <= 1'b0;
            cell_valid_q <= 1'b0;
            cell_addr_q  <= 8'd0;
            cell_alive_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sync_err_q   <= sync_bad && (state_q != ST_UNLOCKED);
            cell_valid_q <= take_cell;
            frame_done_q <= last_cell;
            if (take_cell) begin
                cell_addr_q  <= disp_idx + 8'd1;
                cell_alive_q <= s_q[R1_BIT] & s_q[G1_BIT];
            end
        end
    end

    assign locked     = (state_q != ST_UNLOCKED);
    assign cap_busy   = (state_q == ST_WAIT_FRAME) || (state_q == ST_CAPTURE);
    assign sync_err   = sync_err_q;
    assign cell_valid = cell_valid_q;
    assign cell_addr  = cell_addr_q;
    assign cell_alive = cell_alive_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_board_capture.sv
// tb_vga_board_capture
// Drives a reduced-blanking raster that still contains the full 16x16 board
// window. Each scenario task checks its own results against a pixel
// generator and board model held in the bench.
module tb_vga_board_capture;

    localparam int HT    = 336;
    localparam int VT    = 392;
    localparam int HSS   = 324;
    localparam int VSS   = 386;
    localparam int HSW   = 8;
    localparam int VSW   = 2;
    localparam int VIS_H = 320;
    localparam int VIS_V = 384;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_in = 8'hFF;
    logic       cap_en = 1'b0;
    logic       locked, sync_err, cap_busy, cell_valid, cell_alive, frame_done;
    logic [7:0] cell_addr;

    always #5 clk = ~clk;

    vga_board_capture #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_SYNC_START(HSS),
        .V_SYNC_START(VSS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_in    (vga_in),
        .cap_en    (cap_en),
        .locked    (locked),
        .sync_err  (sync_err),
        .cap_busy  (cap_busy),
        .cell_valid(cell_valid),
        .cell_addr (cell_addr),
        .cell_alive(cell_alive),
        .frame_done(frame_done)
    );

    int   checks = 0;
    int   failures = 0;
    int   gh = 0;
    int   gv = 0;
    int   glitch_line = -1;
    int   cyc = 0;
    logic board [256];

    int   n_valid, n_done, n_err, n_alive_wrong, n_gap8;
    int   first_addr, done_addr, done_nvalid, last_valid_cyc;
    logic done_with_valid, done_busy;
    logic cap_bits [256];
    int   cap_hits [256];

    // Pixel byte of the generator at (h, v); board cell c is shown at display
    // position c-1, lit only in its inner 4x4 pixels.
    function automatic logic [7:0] pix(input int h, input int v);
        logic hs, vs, lit;
        int   col, row, cx, cy, disp;
        if (v == glitch_line) hs = !(h >= HSS + 3 && h < HSS + HSW);
        else                  hs = !(h >= HSS && h < HSS + HSW);
        vs  = !(v >= VSS && v < VSS + VSW);
        lit = 1'b0;
        if (h < VIS_H && v < VIS_V) begin
            if (h >= 192 && v >= 256) begin
                col  = (h - 192) / 8;
                row  = (v - 256) / 8;
                cx   = (h - 192) % 8;
                cy   = (v - 256) % 8;
                disp = row * 16 + (col + 8) % 16;
                lit  = board[(disp + 1) % 256] && cx >= 2 && cx <= 5 && cy >= 2 && cy <= 5;
            end else begin
                lit = 1'b1;
            end
        end
        return {hs, 1'b0, lit, lit, vs, 1'b0, lit, lit};
    endfunction

    task automatic clear_mon();
        n_valid = 0; n_done = 0; n_err = 0; n_alive_wrong = 0; n_gap8 = 0;
        first_addr = -1; done_addr = -1; done_nvalid = -1; last_valid_cyc = 0;
        done_with_valid = 1'b0; done_busy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cap_bits[i] = 1'b0;
            cap_hits[i] = 0;
        end
    endtask

    // One clock: record what the DUT shows, then present the next pixel.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cell_valid) begin
            if (n_valid == 0) first_addr = int'(cell_addr);
            else if (cyc - last_valid_cyc == 8) n_gap8++;
            last_valid_cyc = cyc;
            n_valid++;
            cap_bits[cell_addr] = cell_alive;
            cap_hits[cell_addr]++;
            if (cell_alive !== board[cell_addr]) n_alive_wrong++;
        end
        if (frame_done) begin
            n_done++;
            done_addr       = int'(cell_addr);
            done_with_valid = cell_valid;
            done_nvalid     = n_valid;
            done_busy       = cap_busy;
        end
        if (sync_err) n_err++;
        gh++;
        if (gh == HT) begin
            gh = 0;
            gv++;
            if (gv == VT) gv = 0;
        end
        vga_in = pix(gh, gv);
    endtask

    task automatic run_to(input int h, input int v);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (gh == h && gv == v) break;
            tick();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) board[i] = 1'b0;
        vga_in = pix(0, 0);
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0 || cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: locked=%0b cap_busy=%0b, required 0 0", locked, cap_busy);
        end
        checks++;
        if ({cell_valid, cell_addr, cell_alive} !== 10'd0) begin
            failures++;
            $display("FAIL reset_cell: valid=%0b addr=%0h alive=%0b, required all 0", cell_valid, cell_addr, cell_alive);
        end
        checks++;
        if (sync_err !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: sync_err=%0b frame_done=%0b, required 0 0", sync_err, frame_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        clear_mon();
        run_to(0, VSS);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_early: locked=%0b before first vsync fall, required 0", locked);
        end
        tick();
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_latency: locked=%0b one clock after vsync pin fall, required 0", locked);
        end
        tick();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_rise: locked=%0b two clocks after vsync pin fall, required 1", locked);
        end
        checks++;
        if (n_err != 0 || n_valid != 0 || cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL lock_quiet: sync_err=%0d cells=%0d busy=%0b, required 0 0 0", n_err, n_valid, cap_busy);
        end
    endtask

    task automatic test_all_alive();
        for (int i = 0; i < 256; i++) board[i] = 1'b1;
        clear_mon();
        cap_en = 1'b1;
        for (int k = 0; k < 2 * FRAME && n_done == 0; k++) tick();
        checks++;
        if (n_done != 1 || n_valid != 256) begin
            failures++;
            $display("FAIL alive_count: frame_done=%0d cells=%0d, required 1 256", n_done, n_valid);
        end
        checks++;
        if (n_alive_wrong != 0) begin
            failures++;
            $display("FAIL alive_bits: %0d cells reported dead, required 0", n_alive_wrong);
        end
        checks++;
        if (first_addr != 9) begin
            failures++;
            $display("FAIL alive_first_addr: got %0h, required 09", first_addr);
        end
        checks++;
        if (done_addr != 8'hF8 || done_with_valid !== 1'b1 || done_nvalid != 256) begin
            failures++;
            $display("FAIL alive_done: addr=%0h with_valid=%0b at cell %0d, required f8 1 256", done_addr, done_with_valid, done_nvalid);
        end
        checks++;
        if (n_gap8 != 240) begin
            failures++;
            $display("FAIL alive_spacing: %0d gaps of 8 clocks, required 240", n_gap8);
        end
        checks++;
        if (done_busy !== 1'b0 || n_err != 0) begin
            failures++;
            $display("FAIL alive_idle: busy at done=%0b sync_err=%0d, required 0 0", done_busy, n_err);
        end
        tick();
        checks++;
        if (cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL alive_rearm: cap_busy=%0b with cap_en held, required 1", cap_busy);
        end
        cap_en = 1'b0;
    endtask

    task automatic test_back_to_back_glider();
        for (int i = 0; i < 256; i++) board[i] = 1'b0;
        board[18] = 1'b1; board[35] = 1'b1; board[49] = 1'b1; board[50] = 1'b1; board[51] = 1'b1;
        board[0] = 1'b1; board[128] = 1'b1; board[255] = 1'b1;
        clear_mon();
        for (int k = 0; k < 2 * FRAME && n_done == 0; k++) tick();
        checks++;
        if (n_done != 1 || n_valid != 256 || n_err != 0) begin
            failures++;
            $display("FAIL glider_frame: frame_done=%0d cells=%0d sync_err=%0d, required 1 256 0", n_done, n_valid, n_err);
        end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (cap_hits[i] != 1 || cap_bits[i] !== board[i]) begin
                failures++;
                $display("FAIL glider_cell[%0d]: hits=%0d bit=%0b, required 1 %0b", i, cap_hits[i], cap_bits[i], board[i]);
            end
        end
        tick();
        checks++;
        if (cap_busy !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL glider_idle: cap_busy=%0b locked=%0b, required 0 1", cap_busy, locked);
        end
    endtask

    task automatic test_hsync_glitch();
        clear_mon();
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        tick();
        checks++;
        if (cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_arm: cap_busy=%0b, required 1", cap_busy);
        end
        glitch_line = 300;
        run_to(0, 301);
        glitch_line = -1;
        checks++;
        if (n_err != 1 || locked !== 1'b0 || cap_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_err: sync_err=%0d locked=%0b busy=%0b, required 1 0 0", n_err, locked, cap_busy);
        end
        checks++;
        if (n_valid == 0) begin
            failures++;
            $display("FAIL glitch_midcap: cells before glitch=%0d, required nonzero", n_valid);
        end
        run_to(0, VSS);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL glitch_relock_early: locked=%0b before vsync fall, required 0", locked);
        end
        tick();
        tick();
        checks++;
        if (locked !== 1'b1 || n_done != 0) begin
            failures++;
            $display("FAIL glitch_relock: locked=%0b frame_done=%0d, required 1 0", locked, n_done);
        end
    endtask

    task automatic test_early_cap_en();
        for (int i = 0; i < 256; i++) board[i] = (i % 3 == 0);
        clear_mon();
        run_to(0, VSS + 3);
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        tick();
        checks++;
        if (cap_busy !== 1'b1) begin
            failures++;
            $display("FAIL early_arm: cap_busy=%0b after 1-cycle cap_en, required 1", cap_busy);
        end
        for (int k = 0; k < 2 * FRAME && n_done == 0; k++) tick();
        repeat (HT * 2) tick();
        checks++;
        if (n_done != 1 || n_valid != 256 || n_alive_wrong != 0) begin
            failures++;
            $display("FAIL early_frame: frame_done=%0d cells=%0d wrong=%0d, required 1 256 0", n_done, n_valid, n_alive_wrong);
        end
        checks++;
        if (cap_busy !== 1'b0 || locked !== 1'b1 || n_err != 0) begin
            failures++;
            $display("FAIL early_idle: busy=%0b locked=%0b sync_err=%0d, required 0 1 0", cap_busy, locked, n_err);
        end
    endtask

    task automatic test_reset_mid_capture();
        logic saw_lock;
        clear_mon();
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        run_to(100, 300);
        checks++;
        if (cap_busy !== 1'b1 || n_valid == 0 || cell_addr === 8'd0) begin
            failures++;
            $display("FAIL rstcap_pre: busy=%0b cells=%0d addr=%0h, required 1 nonzero nonzero", cap_busy, n_valid, cell_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, sync_err, cap_busy, cell_valid, cell_addr, cell_alive, frame_done} !== 14'd0) begin
            failures++;
            $display("FAIL rstcap_async: locked=%0b busy=%0b valid=%0b addr=%0h alive=%0b, required all 0",
                     locked, cap_busy, cell_valid, cell_addr, cell_alive);
        end
        tick();
        rst_n = 1'b1;
        clear_mon();
        saw_lock = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (gh == 0 && gv == VSS) break;
            tick();
            if (locked === 1'b1) saw_lock = 1'b1;
        end
        checks++;
        if (saw_lock !== 1'b0 || n_done != 0 || n_valid != 0) begin
            failures++;
            $display("FAIL rstcap_unlocked: early lock=%0b frame_done=%0d cells=%0d, required 0 0 0", saw_lock, n_done, n_valid);
        end
        tick();
        tick();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL rstcap_relock: locked=%0b after vsync fall, required 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_all_alive();
        test_back_to_back_glider();
        test_hsync_glitch();
        test_early_cap_en();
        test_reset_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
